// File: rtl/memory_writeback_cycle.sv
// MEM stage data memory plus MEM/WB register; outputs appear one cycle after inputs.
// No backpressure: one instruction accepted every cycle, no stall or enable.
module memory_writeback_cycle #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        ResultSrcM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   input  logic [4:0]  RdM,
   output logic        RegWriteW,
   output logic [4:0]  RdW,
   output logic [31:0] ResultW,
   output logic [31:0] PCPlus4W
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] word_idx;
   logic [31:0]   read_data;
   logic [31:0]   read_data_w;
   logic [31:0]   alu_result_w;
   logic          result_src_w;

   // Byte offset and bits above the memory size are dropped, so addresses wrap.
   assign word_idx  = ALUResultM[AW+1:2];
   assign read_data = mem[word_idx];

   // Contents survive reset; only the write is suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (MemWriteM && !rst) begin
         mem[word_idx] <= WriteDataM;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteW    <= 1'b0;
         RdW          <= 5'd0;
         PCPlus4W     <= 32'd0;
         read_data_w  <= 32'd0;
         alu_result_w <= 32'd0;
         result_src_w <= 1'b0;
      end else begin
         RegWriteW    <= RegWriteM && (RdM != 5'd0);
         RdW          <= RdM;
         PCPlus4W     <= PCPlus4M;
         read_data_w  <= read_data;
         alu_result_w <= ALUResultM;
         result_src_w <= ResultSrcM;
      end
   end

   assign ResultW = result_src_w ? read_data_w : alu_result_w;

endmodule

// File: doc/memory_writeback_cycle.md
MEMORY_WRITEBACK_CYCLE -- requirements
Module: memory_writeback_cycle

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the data-memory depth in 32-bit words (power of two, 2..1024).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port RegWriteM, input, 1 bit: register-write enable from the EX/MEM register.
REQ-005 SHALL have port ResultSrcM, input, 1 bit: result select (0 = ALU result, 1 = memory load data).
REQ-006 SHALL have port MemWriteM, input, 1 bit: store enable.
REQ-007 SHALL have port ALUResultM, input, 32 bits: byte address for the load or store, and the ALU result.
REQ-008 SHALL have port WriteDataM, input, 32 bits: store data.
REQ-009 SHALL have port PCPlus4M, input, 32 bits: the PC+4 of the instruction.
REQ-010 SHALL have port RdM, input, 5 bits: destination register.
REQ-011 SHALL have port RegWriteW, output, 1 bit: register-file write enable.
REQ-012 SHALL have port RdW, output, 5 bits: register-file write address.
REQ-013 SHALL have port ResultW, output, 32 bits: writeback data, also the forwarding source for the execute stage.
REQ-014 SHALL have port PCPlus4W, output, 32 bits: registered PC+4.

Function
REQ-015 Data memory: SHALL hold DEPTH x 32-bit words, indexed by word index = ALUResultM[log2(DEPTH)+1:2].
- ALUResultM[1:0] SHALL be ignored.
- Higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-016 Store: when MemWriteM=1 and rst=0, WriteDataM SHALL be written to the indexed word on the rising edge of clk.
REQ-017 Load read: SHALL be combinational from the current word index and SHALL return pre-edge contents.
- A store and a load to the same word in the same cycle SHALL return the old data; the new data is visible from the next cycle.
REQ-018 MEM/WB register: SHALL capture ReadData, ALUResultM, PCPlus4M, RdM, ResultSrcM and gated RegWriteM on every rising edge; there is no stall or enable.
REQ-019 RegWrite gating: captured RegWrite SHALL equal RegWriteM AND (RdM != 0), so no write to x0 is ever signalled.
REQ-020 ResultW SHALL be combinational from registered state: ResultSrcW ? ReadDataW : ALUResultW.
REQ-021 Latency: inputs present before edge N SHALL appear on RegWriteW, RdW, ResultW and PCPlus4W after edge N, i.e. one cycle.
REQ-022 MemWriteM=1 together with RegWriteM=1 SHALL perform both the store and the register writeback; there is no priority conflict.
REQ-023 Each input cycle SHALL be independent; back-to-back stores and loads SHALL sustain one instruction per cycle.

Reset
REQ-024 While rst=1, all MEM/WB register fields SHALL be 0: RegWriteW=0, RdW=0, PCPlus4W=0, ReadDataW=0, ALUResultW=0, ResultSrcW=0, so ResultW=0.
REQ-025 Reset SHALL take effect immediately, without waiting for clk.
REQ-026 While rst=1, stores SHALL be suppressed.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Memory contents are undefined at power-up; a bench SHALL write a word before checking a load from it.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight writeback.
- The first instruction after rst deasserts SHALL appear on the outputs one edge later.

Verification
REQ-030 Reset: assert rst between edges with RegWriteM=1 and RdM=5 -> RegWriteW=0, RdW=0 and ResultW=0 immediately, and held at 0 until release.
REQ-031 ALU writeback: ALUResultM=0x1234, ResultSrcM=0, RegWriteM=1, RdM=3 -> after one edge RegWriteW=1, RdW=3, ResultW=0x1234.
REQ-032 Store then load: store 0xDEADBEEF to address 0x10; next cycle load from 0x13 with ResultSrcM=1, RdM=7 -> ResultW=0xDEADBEEF, because bits [1:0] are ignored.
REQ-033 Same-cycle hazard: word at 0x20 holds 0x1; in one cycle store 0x2 to 0x20 and load from 0x20 -> ResultW=0x1; a load in the following cycle -> ResultW=0x2.
REQ-034 Wrap and x0: with DEPTH=64, store 0xA5 to address 0x104, then load from 0x004 -> 0xA5; RegWriteM=1 with RdM=0 -> RegWriteW=0.
REQ-035 Reset suppression: store 0x77 to 0x08 with rst=1 -> a later load from 0x08 returns the prior contents, not 0x77.
